// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor, the fetch mux and the benches.
// Provides:
//   bp_counter_t         - 2-bit saturating direction counter encoding
//   BTB_ENTRIES_DEFAULT  - default BTB depth
//   sat_inc32            - saturating 32-bit increment for statistics counters
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_counter_t;

    localparam int unsigned BTB_ENTRIES_DEFAULT = 16;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_2b.sv
// Next-state logic for one 2-bit saturating branch direction counter.
// Ports:
//   ctr_i    - current counter state
//   taken_i  - resolved branch outcome
//   ctr_o    - next counter state (increments on taken, decrements on not
//              taken, saturating at STRONG_T / STRONG_NT)
module sat_counter_2b
    import branch_predictor_pkg::*;
(
    input  bp_counter_t ctr_i,
    input  logic        taken_i,
    output bp_counter_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            STRONG_NT: ctr_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_o = taken_i ? STRONG_T : WEAK_T;
            default:   ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the RV32i fetch stage.
// A direct-mapped BTB with one 2-bit saturating counter per entry predicts the
// next fetch PC combinationally from PC_F and is trained by resolved branches
// in Execute.
// Ports:
//   CLK, RST          - clock (rising edge), asynchronous active-high reset
//   PC_F              - fetch PC (word aligned)
//   Predict_Taken_F   - BTB hit and counter predicts taken
//   Predict_PC_F      - stored target when predicted taken, else PC_F+4
//   Branch_E          - Execute holds a B-type or JAL (training strobe)
//   PC_E              - PC of the Execute instruction
//   Branch_Taken_E    - resolved outcome
//   Target_E          - resolved target
//   Predict_Taken_E   - prediction that was made for the Execute instruction
//   Branch_Count      - resolved branches seen (saturating)
//   Mispredict_Count  - mispredictions seen (saturating)
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int unsigned INDEX_BITS  = $clog2(BTB_ENTRIES),
    parameter int unsigned TAG_BITS    = 30 - INDEX_BITS
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_F,
    output logic        Predict_Taken_F,
    output logic [31:0] Predict_PC_F,
    input  logic        Branch_E,
    input  logic [31:0] PC_E,
    input  logic        Branch_Taken_E,
    input  logic [31:0] Target_E,
    input  logic        Predict_Taken_E,
    output logic [31:0] Branch_Count,
    output logic [31:0] Mispredict_Count
);

    // Flop arrays rather than RAM so reset can clear every entry asynchronously.
    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [BTB_ENTRIES];
    logic [31:0]         target_q [BTB_ENTRIES];
    bp_counter_t         ctr_q    [BTB_ENTRIES];

    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0]   tag_f;
    logic                  hit_f;

    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  hit_e;
    bp_counter_t           ctr_e_next;

    // Byte-offset bits are always zero for word-aligned PCs.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_F[1:0], PC_E[1:0]};

    // Lookup: purely combinational from registered state, no update bypass.
    assign idx_f = PC_F[INDEX_BITS+1:2];
    assign tag_f = PC_F[31:INDEX_BITS+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign Predict_Taken_F = hit_f && ctr_q[idx_f][1];
    assign Predict_PC_F    = Predict_Taken_F ? target_q[idx_f] : PC_F + 32'd4;

    // Training path.
    assign idx_e = PC_E[INDEX_BITS+1:2];
    assign tag_e = PC_E[31:INDEX_BITS+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    sat_counter_2b u_sat_counter (
        .ctr_i   (ctr_q[idx_e]),
        .taken_i (Branch_Taken_E),
        .ctr_o   (ctr_e_next)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WEAK_NT;
            end
        end else if (Branch_E) begin
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_e_next;
                if (Branch_Taken_E) begin
                    target_q[idx_e] <= Target_E;
                end
            end else if (Branch_Taken_E) begin
                // Allocate on taken miss, evicting whatever aliased here.
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= Target_E;
                ctr_q[idx_e]    <= WEAK_T;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (Branch_E) begin
            branch_count_q <= sat_inc32(branch_count_q);
            if (Branch_Taken_E != Predict_Taken_E) begin
                mispredict_count_q <= sat_inc32(mispredict_count_q);
            end
        end
    end

    assign Branch_Count     = branch_count_q;
    assign Mispredict_Count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        CLK;
    logic        RST;
    logic [31:0] PC_F;
    logic        Predict_Taken_F;
    logic [31:0] Predict_PC_F;
    logic        Branch_E;
    logic [31:0] PC_E;
    logic        Branch_Taken_E;
    logic [31:0] Target_E;
    logic        Predict_Taken_E;
    logic [31:0] Branch_Count;
    logic [31:0] Mispredict_Count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] npc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];

    branch_predictor #(
        .BTB_ENTRIES (16)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .PC_F             (PC_F),
        .Predict_Taken_F  (Predict_Taken_F),
        .Predict_PC_F     (Predict_PC_F),
        .Branch_E         (Branch_E),
        .PC_E             (PC_E),
        .Branch_Taken_E   (Branch_Taken_E),
        .Target_E         (Target_E),
        .Predict_Taken_E  (Predict_Taken_E),
        .Branch_Count     (Branch_Count),
        .Mispredict_Count (Mispredict_Count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (Predict_Taken_F === e.pt) else begin
            errors++;
            $error("FAIL %s.pred_taken got %0b want %0b", e.name, Predict_Taken_F, e.pt);
        end
        checks++;
        assert (Predict_PC_F === e.npc) else begin
            errors++;
            $error("FAIL %s.pred_pc got %08h want %08h", e.name, Predict_PC_F, e.npc);
        end
        checks++;
        assert (Branch_Count === e.bc) else begin
            errors++;
            $error("FAIL %s.branch_count got %0d want %0d", e.name, Branch_Count, e.bc);
        end
        checks++;
        assert (Mispredict_Count === e.mc) else begin
            errors++;
            $error("FAIL %s.mispredict_count got %0d want %0d", e.name, Mispredict_Count, e.mc);
        end
    endtask

    // Drive PC_F, record the expected lookup/statistics, let it settle, compare.
    task automatic expect_at(input string name, input logic [31:0] pc_f, input logic pt,
                             input logic [31:0] npc, input logic [31:0] bc,
                             input logic [31:0] mc);
        exp_t e;
        e.name = name;
        e.pt   = pt;
        e.npc  = npc;
        e.bc   = bc;
        e.mc   = mc;
        sb.push_back(e);
        PC_F = pc_f;
        #1;
        compare_front();
    endtask

    // One training cycle; returns just after the training edge.
    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic pred);
        Branch_E        = 1'b1;
        PC_E            = pc;
        Branch_Taken_E  = tk;
        Target_E        = tgt;
        Predict_Taken_E = pred;
        @(posedge CLK);
        #1;
        Branch_E = 1'b0;
    endtask

    initial begin
        RST             = 1'b1;
        PC_F            = 32'h0;
        Branch_E        = 1'b0;
        PC_E            = 32'h0;
        Branch_Taken_E  = 1'b0;
        Target_E        = 32'h0;
        Predict_Taken_E = 1'b0;
        #2;
        expect_at("reset", 32'h40, 1'b0, 32'h44, 32'd0, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Taken miss allocates at WEAK_T; counted as a mispredict.
        train(32'h40, 1'b1, 32'h100, 1'b0);
        expect_at("alloc", 32'h40, 1'b1, 32'h100, 32'd1, 32'd1);

        // Saturate up, then walk back down.
        train(32'h40, 1'b1, 32'h100, 1'b1);
        train(32'h40, 1'b1, 32'h100, 1'b1);
        train(32'h40, 1'b1, 32'h100, 1'b1);
        expect_at("strong_t", 32'h40, 1'b1, 32'h100, 32'd4, 32'd1);
        train(32'h40, 1'b0, 32'h999, 1'b1);
        expect_at("weak_t", 32'h40, 1'b1, 32'h100, 32'd5, 32'd2);
        train(32'h40, 1'b0, 32'h999, 1'b1);
        expect_at("weak_nt", 32'h40, 1'b0, 32'h44, 32'd6, 32'd3);

        // Alias on index 0 evicts 0x40.
        train(32'h80, 1'b1, 32'h200, 1'b0);
        expect_at("alias_old", 32'h40, 1'b0, 32'h44, 32'd7, 32'd4);
        expect_at("alias_new", 32'h80, 1'b1, 32'h200, 32'd7, 32'd4);

        // Not-taken miss leaves the resident entry alone.
        train(32'hC0, 1'b0, 32'h500, 1'b0);
        expect_at("nt_miss", 32'hC0, 1'b0, 32'hC4, 32'd8, 32'd4);
        expect_at("nt_miss_keep", 32'h80, 1'b1, 32'h200, 32'd8, 32'd4);

        // Taken hit rewrites the target.
        train(32'h80, 1'b1, 32'h300, 1'b1);
        expect_at("retarget", 32'h80, 1'b1, 32'h300, 32'd9, 32'd4);

        // Asynchronous reset in the middle of a training cycle.
        Branch_E        = 1'b1;
        PC_E            = 32'h80;
        Branch_Taken_E  = 1'b1;
        Target_E        = 32'h400;
        Predict_Taken_E = 1'b1;
        #2;
        RST = 1'b1;
        expect_at("async_rst", 32'h80, 1'b0, 32'h84, 32'd0, 32'd0);
        @(posedge CLK);
        #1;
        expect_at("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'd0, 32'd0);
        Branch_E = 1'b0;
        RST      = 1'b0;
        expect_at("rst_cleared", 32'h80, 1'b0, 32'h84, 32'd0, 32'd0);

        // Same-cycle lookup/update of one index sees pre-update state.
        Branch_E        = 1'b1;
        PC_E            = 32'h40;
        Branch_Taken_E  = 1'b1;
        Target_E        = 32'h100;
        Predict_Taken_E = 1'b0;
        expect_at("same_cycle", 32'h40, 1'b0, 32'h44, 32'd0, 32'd0);
        @(posedge CLK);
        #1;
        Branch_E = 1'b0;
        expect_at("next_cycle", 32'h40, 1'b1, 32'h100, 32'd1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage of the RV32i pipeline. A direct-mapped branch target buffer (BTB) holds one 2-bit saturating counter per entry. It predicts the next fetch PC each cycle from PC_F, and trains on resolved branches in Execute. Its Predict_Taken_F travels down the pipeline as Predict_Taken_E and feeds the hazard control unit, which compares it with Branch_Taken_E to raise Flush_D/Flush_E.

## Interface
- BTB_ENTRIES, 16: number of BTB entries; must be a power of two, minimum 2.
- INDEX_BITS, $clog2(BTB_ENTRIES): index width.
- TAG_BITS, 30-INDEX_BITS: tag width, taken from PC[31:INDEX_BITS+2].
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- PC_F  input  32  current fetch PC, word aligned.
- Predict_Taken_F  output  1  BTB hit and counter predicts taken.
- Predict_PC_F  output  32  predicted next PC: stored target if Predict_Taken_F, else PC_F+4.
- Branch_E  input  1  Execute holds a B-type or JAL instruction (never JALR).
- PC_E  input  32  PC of the Execute instruction.
- Branch_Taken_E  input  1  resolved outcome.
- Target_E  input  32  resolved branch target.
- Predict_Taken_E  input  1  prediction made for the Execute instruction.
- Branch_Count  output  32  resolved branches seen, saturating.
- Mispredict_Count  output  32  mispredictions seen, saturating.

## Operation
- Each entry holds: valid (1), tag (TAG_BITS), target (32), counter (2).
- Index = PC[INDEX_BITS+1:2]. Tag = PC[31:INDEX_BITS+2].
- Lookup is combinational from registered state:
  - hit = valid[idx_F] & (tag[idx_F] == tag_F).
  - Predict_Taken_F = hit & counter[idx_F][1].
- Counter encoding: STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
- Update happens at the rising edge when Branch_E=1, using idx_E/tag_E from PC_E.
- Hit, taken: counter increments, saturating at 11; target is written with Target_E.
- Hit, not taken: counter decrements, saturating at 00; target is unchanged.
- Miss, taken: the entry is allocated, overwriting any previous occupant. valid=1, tag=tag_E, target=Target_E, counter=WEAK_T.
- Miss, not taken: no state change.
- Branch_Count increments whenever Branch_E=1.
- Mispredict_Count increments when Branch_E=1 and Branch_Taken_E != Predict_Taken_E.
- Both counters saturate at 32'hFFFF_FFFF.
- PC_En, Stall_En and flush signals are not inputs.
  - Lookup is purely combinational, so stalls need no special handling.
  - A flushed Execute slot arrives with Branch_E=0 and causes no update.

## Timing
- Lookup latency: 0 cycles (combinational on PC_F).
- Update latency: state is visible to lookup in the cycle after the training edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update state. There is no bypass.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all valid=0, tags=0, targets=0, counters=WEAK_NT;
  - Branch_Count=0, Mispredict_Count=0;
  - therefore Predict_Taken_F=0 and Predict_PC_F=PC_F+4.
- PC_F+4 wraps modulo 2^32: PC_F=32'hFFFF_FFFC yields 32'h0000_0000.

## Structure
- Package definitions gains the following, so the predictor, fetch mux and benches share them:
  - typedef enum logic [1:0] bp_counter_t {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T};
  - constant BTB_ENTRIES_DEFAULT = 16.
- Sub-module sat_counter_2b:
  - combinational next-state of one counter from current state and taken bit;
  - instantiated once on the update path, applied to entry idx_E.
- Storage is flop arrays, not inferred RAM, because reset must clear valid bits asynchronously.

## Test plan
- Reset then PC_F=32'h0000_0040 -> Predict_Taken_F=0, Predict_PC_F=32'h0000_0044, both statistics counters 0.
- Train miss: Branch_E=1, PC_E=32'h40, Branch_Taken_E=1, Target_E=32'h100, Predict_Taken_E=0. Next cycle PC_F=32'h40 -> Predict_Taken_F=1, Predict_PC_F=32'h100, Mispredict_Count=1.
- Saturation:
  - from WEAK_T, train PC 32'h40 taken three times -> counter STRONG_T;
  - then train not-taken once -> still predicts taken (WEAK_T);
  - train not-taken once more -> Predict_Taken_F=0, Predict_PC_F=32'h44.
- Alias (BTB_ENTRIES=16): after allocating 32'h40, train PC_E=32'h80 taken with target 32'h200.
  - PC_F=32'h40 -> miss, Predict_Taken_F=0.
  - PC_F=32'h80 -> Predict_PC_F=32'h200.
- Same-cycle hazard: PC_F=PC_E=32'h40 with a taken update on a cleared BTB -> Predict_Taken_F=0 that cycle and 1 the next.
- Assert RST mid-training (between edges) -> Predict_Taken_F drops to 0 immediately and counts read 0; PC_F=32'hFFFF_FFFC gives Predict_PC_F=0.
